mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 64-bit memory between the core's instruction-fetch port and its load/store data port.
- This lets the processor run from a unified instruction/data memory instead of two separate arrays.
- Sits between the processor top level and the memory. Each side uses a req/ack handshake; the requester stalls until ack.
- Round-robin arbitration on contention; fixed, parameterised memory access latency.

Parameters:
addr_bits, 6, width of the 64-bit word address on the memory and data ports.
mem_lat, 1, number of cycles m_en/m_addr must be held before m_rdata is valid (>=1; 1 = combinational-read memory).

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
i_req  input  1  instruction fetch request, held until i_ack
i_addr  input  addr_bits+1  32-bit instruction word address
i_rdata  output  32  fetched instruction, valid while i_ack=1, held afterwards
i_ack  output  1  one-cycle completion pulse for fetch
d_req  input  1  data request, held until d_ack
d_we  input  1  1=store, 0=load
d_addr  input  addr_bits  64-bit word address
d_wdata  input  64  store data
d_rdata  output  64  load data, valid while d_ack=1, held afterwards
d_ack  output  1  one-cycle completion pulse for data
m_en  output  1  memory access active
m_we  output  1  memory write enable
m_addr  output  addr_bits  memory word address
m_wdata  output  64  memory write data
m_rdata  input  64  memory read data

Behaviour:
- Reset (async, rst=1):
  - State IDLE; all outputs 0.
  - last_grant=INSTR, so the first tie goes to data.
  - Any in-flight access is abandoned and no ack is issued. Operation resumes on the first edge after rst falls.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On the grant edge, register m_addr, m_we and m_wdata, set m_en=1, load cnt=mem_lat-1, update last_grant, and go to ACCESS.
- Address and data latching:
  - Data grant: m_addr=d_addr, m_we=d_we, m_wdata=d_wdata.
  - Instruction grant: m_addr=i_addr[addr_bits:1], m_we=0, m_wdata=0. Latch half_sel=i_addr[0].
  - Requester inputs are latched at grant; later changes to them are ignored.
- ACCESS:
  - m_en, m_we, m_addr and m_wdata are held stable.
  - If cnt!=0, decrement cnt.
  - If cnt==0, capture m_rdata into the read register (reads only), clear m_en/m_we, and go to RESP.
  - A store is committed by the memory at that edge. Repeated write edges while m_we is held are idempotent.
  - ACCESS lasts exactly mem_lat cycles.
- RESP:
  - Pulse ack for the granted port for exactly one cycle.
  - i_rdata = half_sel ? word[63:32] : word[31:0] (little-endian halves).
  - d_rdata = captured word on loads. On stores, d_rdata keeps its previous value.
  - In this cycle the just-acked requester's req is ignored, because it is still high from the completed transfer.
  - If the other port's req is high, grant it directly (same register updates as IDLE) and go to ACCESS. Otherwise go to IDLE.
- Latency and throughput:
  - Uncontended: req seen in IDLE at cycle N gives ack at cycle N+mem_lat+1.
  - Single-requester throughput: one transfer every mem_lat+2 cycles.
  - Both requesting continuously: the ports alternate, with one transfer per mem_lat+1 cycles.
- Invariants:
  - i_ack and d_ack are never high together.
  - m_en is never high in IDLE or RESP.
  - Neither ack is ever issued without a preceding grant.
- Protocol violation: if a requester drops req mid-transfer, the access still completes and ack still pulses; no corruption of the other port.

Test Plan:
- mem_lat=1, i_req alone, i_addr=7'd5, mem word 2 = 64'hAAAA_BBBB_1111_2222 -> m_addr=2 for one cycle; i_ack at N+2 with i_rdata=32'hAAAA_BBBB; i_addr=4 on the next fetch returns 32'h1111_2222.
- d_req store d_addr=3, d_wdata=64'hDEAD_BEEF_0000_0001, then load d_addr=3 -> m_we=1 only during the store's ACCESS; the load's d_ack carries 64'hDEAD_BEEF_0000_0001; d_rdata is unchanged at the store's ack.
- i_req and d_req both asserted from reset and held -> grants D,I,D,I...; acks alternate with no idle gap (period mem_lat+1); never both acks high.
- mem_lat=3, single load -> m_en high exactly 3 cycles with a stable address; d_ack at N+4; m_rdata changed in the ACCESS cycles before the last one must not appear on d_rdata.
- rst pulsed while in ACCESS of a data store -> outputs 0 immediately (async); no d_ack; after release with d_req still high, a fresh grant and ack follow normally.
- i_addr and d_wdata changed during ACCESS -> m_addr/m_wdata keep the grant-time values; the returned data matches the latched address.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port 64-bit memory between the
// instruction-fetch (32-bit, half-word select) and load/store data ports.
module mem_port_arbiter #(
  parameter int unsigned addr_bits = 6,
  parameter int unsigned mem_lat   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [addr_bits:0]   i_addr,
  output logic [31:0]          i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [addr_bits-1:0] d_addr,
  input  logic [63:0]          d_wdata,
  output logic [63:0]          d_rdata,
  output logic                 d_ack,
  output logic                 m_en,
  output logic                 m_we,
  output logic [addr_bits-1:0] m_addr,
  output logic [63:0]          m_wdata,
  input  logic [63:0]          m_rdata
);

  localparam int unsigned CNT_W = (mem_lat > 1) ? $clog2(mem_lat) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(mem_lat - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t               state_q, state_d;
  port_t                last_q, last_d, cur_q, cur_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 half_q, half_d;
  logic                 m_en_d, m_we_d;
  logic [addr_bits-1:0] m_addr_d;
  logic [63:0]          m_wdata_d, d_rdata_d;
  logic [31:0]          i_rdata_d;
  logic                 grant, grant_d;

  assign i_ack = (state_q == RESP) && (cur_q == PORT_I);
  assign d_ack = (state_q == RESP) && (cur_q == PORT_D);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    m_en_d    = m_en;
    m_we_d    = m_we;
    m_addr_d  = m_addr;
    m_wdata_d = m_wdata;
    i_rdata_d = i_rdata;
    d_rdata_d = d_rdata;
    grant     = 1'b0;
    grant_d   = 1'b0;

    case (state_q)
      IDLE: begin
        grant   = i_req || d_req;
        grant_d = d_req && (!i_req || (last_q == PORT_I));
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
          m_en_d  = 1'b0;
          m_we_d  = 1'b0;
          if (cur_q == PORT_I)
            i_rdata_d = half_q ? m_rdata[63:32] : m_rdata[31:0];
          else if (!m_we)
            d_rdata_d = m_rdata;
        end
      end
      RESP: begin
        // The just-acked port still holds req from the finished transfer,
        // so only the opposite port may be granted here.
        state_d = IDLE;
        if (cur_q == PORT_I && d_req) begin
          grant   = 1'b1;
          grant_d = 1'b1;
        end else if (cur_q == PORT_D && i_req) begin
          grant   = 1'b1;
          grant_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d = ACCESS;
      m_en_d  = 1'b1;
      cnt_d   = CNT_INIT;
      if (grant_d) begin
        cur_d     = PORT_D;
        last_d    = PORT_D;
        m_addr_d  = d_addr;
        m_we_d    = d_we;
        m_wdata_d = d_wdata;
      end else begin
        cur_d     = PORT_I;
        last_d    = PORT_I;
        m_addr_d  = i_addr[addr_bits:1];
        m_we_d    = 1'b0;
        m_wdata_d = '0;
        half_d    = i_addr[0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= PORT_I;
      cur_q   <= PORT_I;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      m_en    <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      m_en    <= m_en_d;
      m_we    <= m_we_d;
      m_addr  <= m_addr_d;
      m_wdata <= m_wdata_d;
      i_rdata <= i_rdata_d;
      d_rdata <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (mem_lat 1 and 3), each with a
// latency-aware memory model; transactions checked against a reference array.
module tb_mem_port_arbiter;
  localparam int AB = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_req   [2];
  logic [AB:0]   i_addr  [2];
  logic [31:0]   i_rdata [2];
  logic          i_ack   [2];
  logic          d_req   [2];
  logic          d_we    [2];
  logic [AB-1:0] d_addr  [2];
  logic [63:0]   d_wdata [2];
  logic [63:0]   d_rdata [2];
  logic          d_ack   [2];
  logic          m_en    [2];
  logic          m_we    [2];
  logic [AB-1:0] m_addr  [2];
  logic [63:0]   m_wdata [2];
  logic [63:0]   m_rdata [2];

  logic [63:0] mem     [2][64];
  logic [63:0] ref_mem [2][64];
  logic [63:0] junk    [2];
  int          en_cnt  [2];

  int n_checks = 0;
  int n_err    = 0;

  function automatic int lat(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  mem_port_arbiter #(.addr_bits(AB), .mem_lat(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
    .m_en(m_en[0]), .m_we(m_we[0]), .m_addr(m_addr[0]), .m_wdata(m_wdata[0]),
    .m_rdata(m_rdata[0])
  );

  mem_port_arbiter #(.addr_bits(AB), .mem_lat(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
    .m_en(m_en[1]), .m_we(m_we[1]), .m_addr(m_addr[1]), .m_wdata(m_wdata[1]),
    .m_rdata(m_rdata[1])
  );

  // Memory: data valid only once m_en has been held mem_lat-1 full cycles,
  // random garbage otherwise; contents reloaded from the reference during reset.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int a = 0; a < 64; a++) mem[k][a] <= ref_mem[k][a];
        en_cnt[k] <= 0;
      end else begin
        if (m_en[k] && m_we[k]) mem[k][m_addr[k]] <= m_wdata[k];
        en_cnt[k] <= m_en[k] ? en_cnt[k] + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) junk[k] <= {$urandom(), $urandom()};
  end

  always_comb begin
    for (int k = 0; k < 2; k++)
      m_rdata[k] = (m_en[k] && en_cnt[k] >= lat(k) - 1) ? mem[k][m_addr[k]] : junk[k];
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ack_excl[%0d]", k), 64'(i_ack[k] & d_ack[k]), 64'd0);
      chk($sformatf("en_at_ack[%0d]", k), 64'(m_en[k] & (i_ack[k] | d_ack[k])), 64'd0);
    end
  endtask

  task automatic finish(int k, bit is_d, bit we, logic [AB:0] addr, logic [63:0] wd,
                        int exp_lat, bit scr);
    int n = 0;
    int en = 0;
    bit got = 0;
    logic [63:0] prev_d = d_rdata[k];
    logic [AB-1:0] wa = is_d ? addr[AB-1:0] : addr[AB:1];
    logic [63:0] w;
    while (!got && n < 40) begin
      tick();
      n++;
      if (m_en[k]) begin
        en++;
        chk($sformatf("m_addr[%0d]", k), 64'(m_addr[k]), 64'(wa));
        chk($sformatf("m_we[%0d]", k), 64'(m_we[k]), 64'(we));
        chk($sformatf("m_wdata[%0d]", k), m_wdata[k], we ? wd : 64'd0);
      end
      if (i_ack[k] || d_ack[k]) got = 1;
      if (scr && n == 1) begin
        i_addr[k]  = 7'($urandom());
        d_addr[k]  = 6'($urandom());
        d_wdata[k] = {$urandom(), $urandom()};
        d_we[k]    = 1'($urandom());
      end
    end
    chk($sformatf("ack_seen[%0d]", k), 64'(got), 64'd1);
    chk($sformatf("latency[%0d]", k), 64'(n), 64'(exp_lat));
    chk($sformatf("en_cycles[%0d]", k), 64'(en), 64'(lat(k)));
    chk($sformatf("ack_port[%0d]", k), 64'(d_ack[k]), 64'(is_d));
    w = ref_mem[k][wa];
    if (is_d && we) begin
      chk($sformatf("st_hold[%0d]", k), d_rdata[k], prev_d);
      ref_mem[k][wa] = wd;
    end else if (is_d) begin
      chk($sformatf("ld_data[%0d]", k), d_rdata[k], w);
    end else begin
      chk($sformatf("if_data[%0d]", k), 64'(i_rdata[k]), 64'(addr[0] ? w[63:32] : w[31:0]));
    end
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    tick();
  endtask

  task automatic xfer(int k, bit is_d, bit we, logic [AB:0] addr, logic [63:0] wd, bit scr);
    if (is_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr[AB-1:0]; d_wdata[k] = wd;
    end else begin
      i_req[k] = 1'b1; i_addr[k] = addr;
    end
    finish(k, is_d, we, addr, wd, lat(k) + 1, scr);
  endtask

  // Both ports held high from a fresh reset: data wins first, then strict
  // alternation with one ack every mem_lat+1 cycles.
  task automatic contend(int k, logic [AB:0] ia, logic [AB-1:0] da, int nacks);
    int n = 0;
    int last = 0;
    int cnt = 0;
    bit exp_d = 1;
    logic [63:0] w;
    i_req[k] = 1'b1; i_addr[k] = ia;
    d_req[k] = 1'b1; d_we[k] = 1'b0; d_addr[k] = da;
    while (cnt < nacks && n < 200) begin
      tick();
      n++;
      if (i_ack[k] || d_ack[k]) begin
        chk($sformatf("alt_port[%0d]", k), 64'(d_ack[k]), 64'(exp_d));
        chk($sformatf("alt_gap[%0d]", k), 64'(n - last), 64'(lat(k) + 1));
        if (d_ack[k]) begin
          chk($sformatf("alt_ld[%0d]", k), d_rdata[k], ref_mem[k][da]);
        end else begin
          w = ref_mem[k][ia[AB:1]];
          chk($sformatf("alt_if[%0d]", k), 64'(i_rdata[k]), 64'(ia[0] ? w[63:32] : w[31:0]));
        end
        exp_d = !exp_d;
        last = n;
        cnt++;
      end
    end
    chk($sformatf("alt_count[%0d]", k), 64'(cnt), 64'(nacks));
    i_req[k] = 1'b0;
    d_req[k] = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0;
      for (int a = 0; a < 64; a++) ref_mem[k][a] = {$urandom(), $urandom()};
    end
    ref_mem[0][2] = 64'hAAAA_BBBB_1111_2222;

    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_m_en[%0d]", k), 64'(m_en[k]), 64'd0);
      chk($sformatf("rst_m_addr[%0d]", k), 64'(m_addr[k]), 64'd0);
      chk($sformatf("rst_acks[%0d]", k), 64'({i_ack[k], d_ack[k]}), 64'd0);
      chk($sformatf("rst_rdata[%0d]", k), d_rdata[k] | 64'(i_rdata[k]), 64'd0);
    end
    rst = 1'b0;
    tick();

    contend(0, 7'd9, 6'd1, 6);
    contend(1, 7'd12, 6'd7, 4);

    xfer(0, 1'b0, 1'b0, 7'd5, 64'd0, 1'b0);
    chk("fetch_hi", 64'(i_rdata[0]), 64'h0000_0000_AAAA_BBBB);
    xfer(0, 1'b0, 1'b0, 7'd4, 64'd0, 1'b0);
    chk("fetch_lo", 64'(i_rdata[0]), 64'h0000_0000_1111_2222);
    xfer(0, 1'b1, 1'b1, 7'd3, 64'hDEAD_BEEF_0000_0001, 1'b0);
    xfer(0, 1'b1, 1'b0, 7'd3, 64'd0, 1'b0);
    chk("load_back", d_rdata[0], 64'hDEAD_BEEF_0000_0001);

    xfer(1, 1'b1, 1'b0, 7'd10, 64'd0, 1'b0);
    xfer(1, 1'b1, 1'b1, 7'd20, 64'h0123_4567_89AB_CDEF, 1'b1);
    xfer(1, 1'b1, 1'b0, 7'd20, 64'd0, 1'b1);
    chk("scr_load", d_rdata[1], 64'h0123_4567_89AB_CDEF);
    xfer(1, 1'b0, 1'b0, 7'd41, 64'd0, 1'b1);

    // Reset pulse during the ACCESS phase of a store on the mem_lat=3 port.
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 6'd33; d_wdata[1] = 64'hCAFE_F00D_5555_AAAA;
    tick();
    tick();
    chk("pre_rst_en", 64'(m_en[1]), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_out", 64'({m_en[1], m_we[1], d_ack[1], i_ack[1]}), 64'd0);
    chk("rst_async_addr", 64'(m_addr[1]), 64'd0);
    chk("rst_async_wdata", m_wdata[1], 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    finish(1, 1'b1, 1'b1, 7'd33, 64'hCAFE_F00D_5555_AAAA, lat(1) + 2, 1'b0);
    xfer(1, 1'b1, 1'b0, 7'd33, 64'd0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      int k = int'($urandom_range(0, 1));
      int kind = int'($urandom_range(0, 2));
      xfer(k, kind != 0, kind == 2, 7'($urandom()), {$urandom(), $urandom()},
           $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
